// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM states, accumulator sizing and requantisation for fc_layer_seq
package fc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_QUANT, S_DONE} fc_state_t;
  typedef struct packed {
    logic signed [31:0] val;
    logic sat;
  } rq_t;
  function automatic int acc_width(input int data_w, input int in_size);
    return 2 * data_w + $clog2(in_size) + 1;
  endfunction
  function automatic rq_t requant(input logic signed [63:0] acc, input int frac, input int dw, input int relu);
    rq_t o;
    logic signed [63:0] r, mx, mn;
    mx = (64'sd1 <<< (dw - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (dw - 1));
    r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    if (relu != 0 && r < 0) r = '0;
    o.sat = (r > mx) || (r < mn);
    o.val = 32'(r > mx ? mx : r < mn ? mn : r);
    return o;
  endfunction
endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one MAC lane with bias preload and requantised output
module fc_mac_lane import fc_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int RELU      = 1,
  parameter int ACC_W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_bias,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic signed [DATA_W-1:0] i_x,
  output logic        [DATA_W-1:0] o_q,
  output logic                     o_sat
);
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prod;
  rq_t w_rq;
  assign w_prod = ACC_W'(i_w) * ACC_W'(i_x);
  assign w_rq   = requant(64'(r_acc), FRAC_BITS, DATA_W, RELU);
  assign o_q    = w_rq.val[DATA_W-1:0];
  assign o_sat  = w_rq.sat;
  // accumulator: bias (in Q format) on the first MAC cycle, then one product per cycle
  always_ff @(posedge clk) begin
    if (rst) r_acc <= '0;
    else if (i_load) r_acc <= ACC_W'(i_bias) <<< FRAC_BITS;
    else if (i_en) r_acc <= r_acc + w_prod;
  end
endmodule

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: time-multiplexed fully connected layer with streamed weights
module fc_layer_seq import fc_pkg::*; #(
  parameter int IN_SIZE   = 16,
  parameter int OUT_SIZE  = 16,
  parameter int LANES     = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int RELU      = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [IN_SIZE-1:0][DATA_W-1:0]                 input_vector,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [OUT_SIZE-1:0][DATA_W-1:0]                biases,
  output logic                                           w_en,
  output logic [$clog2(OUT_SIZE/LANES*IN_SIZE)-1:0]      w_addr,
  input  logic [LANES-1:0][DATA_W-1:0]                   w_data,
  output logic [OUT_SIZE-1:0][DATA_W-1:0]                output_vector,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           sat_flag
);
  localparam int G     = OUT_SIZE / LANES;
  localparam int AW    = $clog2(G * IN_SIZE);
  localparam int KW    = IN_SIZE > 1 ? $clog2(IN_SIZE) : 1;
  localparam int GW    = G > 1 ? $clog2(G) : 1;
  localparam int ACC_W = acc_width(DATA_W, IN_SIZE);
  fc_state_t r_state, w_next;
  logic [IN_SIZE-1:0][DATA_W-1:0]  r_x;
  logic [OUT_SIZE-1:0][DATA_W-1:0] r_out;
  logic [KW-1:0]                   r_k, r_kd;
  logic [GW-1:0]                   r_g;
  logic                            r_sat;
  logic [LANES-1:0][DATA_W-1:0]    w_q;
  logic [LANES-1:0]                w_sat;
  logic w_last_k, w_last_g, w_load, w_acc;
  assign w_last_k      = r_k == KW'(IN_SIZE - 1);
  assign w_last_g      = r_g == GW'(G - 1);
  assign w_load        = r_state == S_MAC && r_k == '0;
  assign w_acc         = (r_state == S_MAC && r_k != '0) || r_state == S_DRAIN;
  assign in_ready      = r_state == S_IDLE;
  assign out_valid     = r_state == S_DONE;
  assign w_en          = r_state == S_MAC;
  assign w_addr        = w_en ? AW'(int'(r_g) * IN_SIZE + int'(r_k)) : '0;
  assign output_vector = r_out;
  assign sat_flag      = r_sat;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_mac_lane #(
      .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .RELU(RELU), .ACC_W(ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_en   (w_acc),
      .i_bias (biases[int'(r_g) * LANES + l]),
      .i_w    (w_data[l]),
      .i_x    (r_x[r_kd]),
      .o_q    (w_q[l]),
      .o_sat  (w_sat[l])
    );
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next-state: MAC/DRAIN/QUANT per group, DONE after the last group
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = in_valid ? S_MAC : S_IDLE;
      S_MAC:   w_next = w_last_k ? S_DRAIN : S_MAC;
      S_DRAIN: w_next = S_QUANT;
      S_QUANT: w_next = w_last_g ? S_DONE : S_MAC;
      S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // input latch, k/group counters (r_kd tracks k of the weight now arriving) and output file
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_out <= '0;
      r_k   <= '0;
      r_kd  <= '0;
      r_g   <= '0;
      r_sat <= 1'b0;
    end else begin
      r_kd <= r_k;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x   <= input_vector;
          r_k   <= '0;
          r_g   <= '0;
          r_sat <= 1'b0;
        end
        S_MAC: r_k <= w_last_k ? '0 : r_k + KW'(1);
        S_QUANT: begin
          for (int l = 0; l < LANES; l++) r_out[int'(r_g) * LANES + l] <= w_q[l];
          r_sat <= r_sat | (|w_sat);
          r_g   <= w_last_g ? r_g : r_g + GW'(1);
          r_k   <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: directed checks of fc_layer_seq with ReLU and linear instances
module tb_fc_layer_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0][15:0] iv = '0;
  logic [15:0][15:0] bs = '0;
  logic [3:0][15:0]  wd_a, wd_b;
  logic [15:0][15:0] out_a, out_b, snap;
  logic [5:0]        wa_a, wa_b, a0, a19;
  logic ir_a, ir_b, ov_a, ov_b, we_a, we_b, sat_a, sat_b, e0, e16;
  logic [15:0] wm [16][16];
  logic [15:0] e;
  int n_pass = 0;
  int n_chk = 0;
  int lat;
  always #5 clk = ~clk;
  fc_layer_seq #(.RELU(1)) u_a (
    .clk(clk), .rst(rst), .input_vector(iv), .in_valid(in_valid), .in_ready(ir_a),
    .biases(bs), .w_en(we_a), .w_addr(wa_a), .w_data(wd_a), .output_vector(out_a),
    .out_valid(ov_a), .out_ready(out_ready), .sat_flag(sat_a)
  );
  fc_layer_seq #(.RELU(0)) u_b (
    .clk(clk), .rst(rst), .input_vector(iv), .in_valid(in_valid), .in_ready(ir_b),
    .biases(bs), .w_en(we_b), .w_addr(wa_b), .w_data(wd_b), .output_vector(out_b),
    .out_valid(ov_b), .out_ready(out_ready), .sat_flag(sat_b)
  );
  // weight memory model with one-cycle read latency, one copy per instance
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      wd_a[l] <= wm[int'(wa_a) / 16 * 4 + l][int'(wa_a) % 16];
      wd_b[l] <= wm[int'(wa_b) / 16 * 4 + l][int'(wa_b) % 16];
    end
  end
  task automatic fill_w(input logic [15:0] v);
    for (int n = 0; n < 16; n++) for (int k = 0; k < 16; k++) wm[n][k] = v;
  endtask
  task automatic accept();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    e0 = we_a;
    a0 = wa_a;
  endtask
  task automatic wait_valid();
    lat = 0;
    while (!ov_a && lat < 200) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 16) e16 = we_a;
      if (lat == 19) a19 = wa_a;
    end
  endtask
  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_chk++; if (ir_a !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir_a); else n_pass++;
    n_chk++; if (ov_a !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ov_a); else n_pass++;
    n_chk++; if (we_a !== 1'b0) $display("FAIL reset_w_en got %b want 0", we_a); else n_pass++;
    n_chk++; if (wa_a !== 6'd0) $display("FAIL reset_w_addr got %0d want 0", wa_a); else n_pass++;
    n_chk++; if (out_a !== '0) $display("FAIL reset_outputs got %h want 0", out_a); else n_pass++;
    n_chk++; if (sat_a !== 1'b0) $display("FAIL reset_sat got %b want 0", sat_a); else n_pass++;
  endtask
  task automatic test_identity(input string tag);
    for (int n = 0; n < 16; n++) for (int k = 0; k < 16; k++) wm[n][k] = (n == k) ? 16'd256 : 16'd0;
    bs = '0;
    for (int k = 0; k < 16; k++) iv[k] = 16'((k - 8) * 256);
    accept();
    wait_valid();
    n_chk++; if (lat !== 72) $display("FAIL %s_latency got %0d want 72", tag, lat); else n_pass++;
    n_chk++; if (e0 !== 1'b1 || a0 !== 6'd0) $display("FAIL %s_first_read got en=%b addr=%0d want en=1 addr=0", tag, e0, a0); else n_pass++;
    n_chk++; if (e16 !== 1'b0) $display("FAIL %s_drain_w_en got %b want 0", tag, e16); else n_pass++;
    n_chk++; if (a19 !== 6'd17) $display("FAIL %s_group1_addr got %0d want 17", tag, a19); else n_pass++;
    n_chk++; if (ir_a !== 1'b0) $display("FAIL %s_in_ready_done got %b want 0", tag, ir_a); else n_pass++;
    n_chk++; if (sat_a !== 1'b0 || sat_b !== 1'b0) $display("FAIL %s_sat got %b/%b want 0/0", tag, sat_a, sat_b); else n_pass++;
    for (int n = 0; n < 16; n++) begin
      e = (n < 8) ? 16'd0 : 16'((n - 8) * 256);
      n_chk++; if (out_a[n] !== e) $display("FAIL %s_relu[%0d] got %0d want %0d", tag, n, $signed(out_a[n]), $signed(e)); else n_pass++;
      e = 16'((n - 8) * 256);
      n_chk++; if (out_b[n] !== e) $display("FAIL %s_lin[%0d] got %0d want %0d", tag, n, $signed(out_b[n]), $signed(e)); else n_pass++;
    end
    release_out();
  endtask
  task automatic test_bias();
    fill_w(16'd0);
    for (int n = 0; n < 16; n++) bs[n] = 16'(16 * n);
    for (int k = 0; k < 16; k++) iv[k] = 16'(k * 3 + 1);
    accept();
    wait_valid();
    n_chk++; if (lat !== 72) $display("FAIL bias_latency got %0d want 72", lat); else n_pass++;
    for (int n = 0; n < 16; n++) begin
      e = 16'(16 * n);
      n_chk++; if (out_a[n] !== e || out_b[n] !== e) $display("FAIL bias[%0d] got %0d/%0d want %0d", n, out_a[n], out_b[n], e); else n_pass++;
    end
    release_out();
    bs[3] = 16'hFF9C;
    accept();
    wait_valid();
    n_chk++; if (out_b[3] !== 16'hFF9C) $display("FAIL bias_neg_lin got %0d want -100", $signed(out_b[3])); else n_pass++;
    n_chk++; if (out_a[3] !== 16'd0) $display("FAIL bias_neg_relu got %0d want 0", $signed(out_a[3])); else n_pass++;
    n_chk++; if (out_b[5] !== 16'd80) $display("FAIL bias_other got %0d want 80", out_b[5]); else n_pass++;
    release_out();
  endtask
  task automatic test_saturation();
    fill_w(16'd32767);
    bs = '0;
    for (int k = 0; k < 16; k++) iv[k] = 16'd32767;
    accept();
    wait_valid();
    n_chk++; if (sat_a !== 1'b1 || sat_b !== 1'b1) $display("FAIL sat_pos_flag got %b/%b want 1/1", sat_a, sat_b); else n_pass++;
    for (int n = 0; n < 16; n++) begin
      n_chk++; if (out_a[n] !== 16'h7FFF || out_b[n] !== 16'h7FFF) $display("FAIL sat_pos[%0d] got %h/%h want 7fff", n, out_a[n], out_b[n]); else n_pass++;
    end
    release_out();
    fill_w(16'h8001);
    accept();
    wait_valid();
    n_chk++; if (sat_b !== 1'b1) $display("FAIL sat_neg_flag_lin got %b want 1", sat_b); else n_pass++;
    n_chk++; if (sat_a !== 1'b0) $display("FAIL sat_neg_flag_relu got %b want 0", sat_a); else n_pass++;
    for (int n = 0; n < 16; n++) begin
      n_chk++; if (out_b[n] !== 16'h8000 || out_a[n] !== 16'h0000) $display("FAIL sat_neg[%0d] got %h/%h want 0000/8000", n, out_a[n], out_b[n]); else n_pass++;
    end
    release_out();
  endtask
  task automatic test_rounding();
    logic [3:0][15:0] exp_l, exp_r;
    fill_w(16'd0);
    wm[0][0] = 16'd128;
    wm[1][0] = 16'd127;
    wm[2][0] = 16'hFF80;
    wm[3][0] = 16'hFF7F;
    bs = '0;
    iv = '0;
    iv[0] = 16'd1;
    exp_l = {16'hFFFF, 16'd0, 16'd0, 16'd1};
    exp_r = {16'd0, 16'd0, 16'd0, 16'd1};
    accept();
    wait_valid();
    n_chk++; if (sat_b !== 1'b0) $display("FAIL round_sat_cleared got %b want 0", sat_b); else n_pass++;
    for (int n = 0; n < 4; n++) begin
      n_chk++; if (out_b[n] !== exp_l[n]) $display("FAIL round_lin[%0d] got %0d want %0d", n, $signed(out_b[n]), $signed(exp_l[n])); else n_pass++;
      n_chk++; if (out_a[n] !== exp_r[n]) $display("FAIL round_relu[%0d] got %0d want %0d", n, $signed(out_a[n]), $signed(exp_r[n])); else n_pass++;
    end
    release_out();
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 16; n++) for (int k = 0; k < 16; k++) wm[n][k] = (n == k) ? 16'd256 : 16'd0;
    bs = '0;
    for (int k = 0; k < 16; k++) iv[k] = 16'((k - 8) * 256);
    accept();
    wait_valid();
    snap = out_a;
    for (int k = 0; k < 16; k++) iv[k] = 16'((15 - k) * 256);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n_chk++; if (ir_a !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", c, ir_a); else n_pass++;
      n_chk++; if (ov_a !== 1'b1) $display("FAIL bp_out_valid[%0d] got %b want 1", c, ov_a); else n_pass++;
      n_chk++; if (out_a !== snap) $display("FAIL bp_stable[%0d] got %h want %h", c, out_a, snap); else n_pass++;
    end
    release_out();
    n_chk++; if (ir_a !== 1'b1 || ov_a !== 1'b0) $display("FAIL bp_after_hs got ready=%b valid=%b want 1/0", ir_a, ov_a); else n_pass++;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_chk++; if (ir_a !== 1'b0) $display("FAIL bp_reaccept got in_ready=%b want 0", ir_a); else n_pass++;
    wait_valid();
    n_chk++; if (lat !== 72) $display("FAIL bp_latency got %0d want 72", lat); else n_pass++;
    for (int n = 0; n < 16; n++) begin
      e = 16'((15 - n) * 256);
      n_chk++; if (out_a[n] !== e) $display("FAIL bp_new[%0d] got %0d want %0d", n, $signed(out_a[n]), $signed(e)); else n_pass++;
    end
    release_out();
  endtask
  task automatic test_reset_mid();
    for (int k = 0; k < 16; k++) iv[k] = 16'((k - 8) * 256);
    accept();
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_chk++; if (ir_a !== 1'b1) $display("FAIL rmid_in_ready got %b want 1", ir_a); else n_pass++;
    n_chk++; if (ov_a !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", ov_a); else n_pass++;
    n_chk++; if (out_a !== '0 || out_b !== '0) $display("FAIL rmid_outputs got %h want 0", out_a); else n_pass++;
    n_chk++; if (we_a !== 1'b0 || sat_a !== 1'b0) $display("FAIL rmid_wen_sat got %b/%b want 0/0", we_a, sat_a); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (ov_a !== 1'b0 || ir_a !== 1'b1) $display("FAIL rmid_idle_hold got valid=%b ready=%b want 0/1", ov_a, ir_a); else n_pass++;
    test_identity("post_reset");
  endtask
  initial begin
    fill_w(16'd0);
    test_reset();
    test_identity("ident");
    test_bias();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fc_layer_seq.md
# fc_layer_seq

Time-multiplexed, parametrised fully connected layer for the quantized MNIST datapath. It computes `OUT_SIZE` neurons over an `IN_SIZE` input vector using `LANES` shared MAC lanes. Weights are streamed from an external weight memory; accumulation is in Q-format fixed point, followed by round, optional ReLU and saturate. It sits between consecutive layer stages and exchanges whole vectors with them over valid/ready handshakes.

## Interface
- `IN_SIZE`, 16, number of inputs per neuron
- `OUT_SIZE`, 16, number of neurons; must be a multiple of `LANES`
- `LANES`, 4, parallel MAC lanes; G = `OUT_SIZE/LANES` neuron groups
- `DATA_W`, 16, signed width of inputs, weights, biases and outputs
- `FRAC_BITS`, 8, fractional bits of the Q format (1.0 = 256)
- `RELU`, 1, 1 clamps negative results to 0; 0 passes them through
- `clk` in 1: single clock, all logic on its rising edge
- `rst` in 1: reset, synchronous and active-high
- `input_vector` in `IN_SIZE`×`DATA_W`: signed inputs, sampled on accept
- `in_valid` in 1: input vector offered
- `in_ready` out 1: block can accept a vector
- `biases` in `OUT_SIZE`×`DATA_W`: signed biases; must be held static during an inference
- `w_en` out 1: weight read strobe
- `w_addr` out `$clog2(G*IN_SIZE)`: equals group*`IN_SIZE` + k
- `w_data` in `LANES`×`DATA_W`: lane l carries the weight for neuron group*`LANES`+l and input k; fixed 1-cycle read latency
- `output_vector` out `OUT_SIZE`×`DATA_W`: signed results, stable while `out_valid`=1
- `out_valid` out 1: result vector available
- `out_ready` in 1: downstream accepts the result
- `sat_flag` out 1: at least one output saturated in this inference; valid with `out_valid`

## Operation
- States: IDLE, MAC, DRAIN, QUANT, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `input_vector` into internal registers, set group=0 and k=0, clear `sat_flag`, go to MAC.
  - `input_vector` may change freely after the accept.
- MAC (`IN_SIZE` cycles)
  - `w_en`=1 and `w_addr`=group*`IN_SIZE`+k, with k = 0..`IN_SIZE`-1.
  - The lane accumulators are preloaded with `bias`<<`FRAC_BITS` on the first MAC cycle.
  - `w_data` is sampled one cycle after its address. Each lane does acc += w_data[l]*x[k].
- DRAIN (1 cycle): `w_en`=0; the last product is accumulated.
- QUANT (1 cycle)
  - Per lane: r = (acc + 2^(`FRAC_BITS`-1)) >>> `FRAC_BITS`, which is round-half-up using an arithmetic shift.
  - If `RELU`=1, r<0 becomes 0.
  - r is saturated to [-2^(`DATA_W`-1), 2^(`DATA_W`-1)-1]. Any clip sets `sat_flag`.
  - The group's `LANES` words are written into `output_vector`.
  - If this is the last group, go to DONE. Otherwise increment group, set k=0, go to MAC.
- DONE
  - `out_valid`=1; `output_vector` and `sat_flag` are held.
  - On `out_ready`, go to IDLE.
- Accumulator width is ACC_W = 2·`DATA_W` + `$clog2(IN_SIZE)` + 1. No overflow is possible inside the accumulator.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Outputs of groups not yet recomputed keep their previous-inference values until overwritten. Consumers read only while `out_valid`=1.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1, `out_valid`=0
  - `w_en`=0, `w_addr`=0
  - `output_vector` all 0, `sat_flag`=0
- `rst` has priority over all events. Reset asserted mid-inference abandons the computation. The next cycle after reset is IDLE, with no `out_valid` pulse.
- Latency: `out_valid` rises G·(`IN_SIZE`+2) cycles after the accepting edge. With defaults that is 72 cycles.
- Throughput: one vector per G·(`IN_SIZE`+2)+2 cycles with `out_ready` held at 1.
- Handshake boundaries:
  - `in_ready` is low from the accepting edge until the cycle after the output handshake.
  - A new vector can be accepted the cycle after `out_valid`&`out_ready`.
  - `out_valid` stays high indefinitely under backpressure.

## Structure
- Shared package `fc_pkg` holds:
  - the state enum `fc_state_t`
  - a `acc_width(DATA_W, IN_SIZE)` function
  - a `requant` function (round, ReLU, saturate), returning the value and a sat bit
- Sub-module `fc_mac_lane`, instantiated `LANES` times. It contains one accumulator with bias preload, a MAC enable, and a requant output with a sat bit.
- The top level owns the FSM, the counters, the input latch and the output register file.

## Test plan
1. **Identity with ReLU.** Defaults, `RELU`=1, w[n][k]=256 if n==k else 0, biases 0, x[k]=(k−8)·256.
   - Expect output[n]=0 for n<8 and (n−8)·256 for n≥8.
   - `out_valid` exactly 72 cycles after accept; `sat_flag`=0.
2. **Bias only.** All weights 0, biases[n]=16·n; then `RELU`=0 with biases[3]=−100.
   - Expect output[n]=16·n; then output[3]=−100.
3. **Saturation.** All weights and inputs 32767.
   - Expect every output 32767 and `sat_flag`=1.
   - With weights −32767 and `RELU`=0, expect −32768.
4. **Rounding.** x[0]=1, others 0, biases 0.
   - w[0][0]=128 gives 1; 127 gives 0; −128 gives 0; −129 gives −1 (with `RELU`=0).
5. **Backpressure.** Hold `out_ready`=0 for 10 cycles after `out_valid`, and pulse `in_valid` meanwhile.
   - Outputs stay stable, `in_ready`=0, the pulses are ignored.
   - After the output handshake, a new vector is accepted the following cycle.
6. **Reset mid-MAC.** Assert `rst` 30 cycles after accept.
   - Next cycle: `in_ready`=1, `out_valid`=0, outputs 0.
   - A subsequent identity inference matches scenario 1.
